// File: rtl/disp_scan_mux.sv
// N-digit multiplexed 7-segment scanner with anti-ghost blanking and brightness.
// Optional per-digit blink is built when DISP_BLINK_EN is defined.
module disp_scan_mux #(
  parameter int N_DIG     = 4,
  parameter int SCAN_DIV  = 512,
  parameter int BLANK_CYC = 128,
  parameter int BLINK_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7*N_DIG-1:0]       seg_in,
  input  logic [N_DIG-1:0]         dp_in,
  input  logic [N_DIG-1:0]         dig_en,
  input  logic [3:0]               bright,
  input  logic [N_DIG-1:0]         blink_mask,
  output logic [6:0]               seg_out,
  output logic                     dp_out,
  output logic [N_DIG-1:0]         sel_out,
  output logic [$clog2(N_DIG)-1:0] cur_dig,
  output logic                     frame_tick
);

  localparam int CW  = $clog2(SCAN_DIV);
  localparam int CW1 = CW + 1;
  localparam int DW  = $clog2(N_DIG);
  localparam int U   = (SCAN_DIV - BLANK_CYC) / 16;

  typedef enum logic [1:0] {
    ST_BLANK,
    ST_ON,
    ST_OFF
  } st_e;

  logic [CW-1:0]    c_q, c_d;
  logic [DW-1:0]    dig_q, dig_d;
  st_e              st_q, st_d;
  logic [6:0]       seg_s_q, seg_s_d;
  logic             dp_s_q, dp_s_d;
  logic             en_s_q, en_s_d;
  logic [3:0]       br_q, br_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [N_DIG-1:0] sel_q, sel_d;
  logic [DW-1:0]    cur_q, cur_d;
  logic             ft_q, ft_d;

  logic             wrap;
  logic             last;
  logic [CW1-1:0]   on_end;
  logic             blink_dark;
  logic             lit;

  assign wrap   = (c_q == CW'(SCAN_DIV - 1));
  assign last   = (dig_q == DW'(N_DIG - 1));
  assign on_end = CW1'(BLANK_CYC)
                + (CW1'(br_q) + CW1'(1)) * CW1'(U);

`ifdef DISP_BLINK_EN
  logic [BLINK_W-1:0] bcnt_q, bcnt_d;
  logic               bph_q, bph_d;

  // Blink counter advances per frame; phase flips on counter wrap
  always_comb begin
    bcnt_d = bcnt_q;
    bph_d  = bph_q;
    if (blink_mask == '0) begin
      bcnt_d = '0;
      bph_d  = 1'b0;
    end else if (wrap && last) begin
      bcnt_d = bcnt_q + BLINK_W'(1);
      if (&bcnt_q) bph_d = ~bph_q;
    end
  end

  // Blink state register
  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt_q <= '0;
      bph_q  <= 1'b0;
    end else begin
      bcnt_q <= bcnt_d;
      bph_q  <= bph_d;
    end
  end

  assign blink_dark = bph_q & blink_mask[dig_q];
`else
  logic unused_blink;
  assign unused_blink = ^blink_mask;
  assign blink_dark   = 1'b0;
`endif

  // Slot counter, digit index and per-slot input snapshot
  always_comb begin
    c_d     = wrap ? '0 : c_q + CW'(1);
    dig_d   = dig_q;
    seg_s_d = seg_s_q;
    dp_s_d  = dp_s_q;
    en_s_d  = en_s_q;
    br_d    = br_q;
    if (wrap) dig_d = last ? '0 : dig_q + DW'(1);
    if (c_q == '0) begin
      seg_s_d = seg_in[7*int'(dig_q) +: 7];
      dp_s_d  = dp_in[dig_q];
      en_s_d  = dig_en[dig_q];
      br_d    = bright;
    end
  end

  // Slot phase FSM: blank, on-window, off until the slot wraps
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      ST_BLANK: if (c_q == CW'(BLANK_CYC - 1)) st_d = ST_ON;
      ST_ON: begin
        if (wrap) st_d = ST_BLANK;
        else if ({1'b0, c_q} == on_end - CW1'(1)) st_d = ST_OFF;
      end
      ST_OFF:   if (wrap) st_d = ST_BLANK;
      default:  st_d = ST_BLANK;
    endcase
  end

  // Registered display outputs derived from current slot state
  always_comb begin
    lit   = (st_q == ST_ON) && en_s_q && !blink_dark;
    seg_d = lit ? seg_s_q : 7'h7F;
    dp_d  = lit ? ~dp_s_q : 1'b1;
    sel_d = lit ? ~(N_DIG'(1) << dig_q) : '1;
    cur_d = dig_q;
    ft_d  = wrap && last;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      c_q     <= '0;
      dig_q   <= '0;
      st_q    <= ST_BLANK;
      seg_s_q <= 7'h7F;
      dp_s_q  <= 1'b0;
      en_s_q  <= 1'b0;
      br_q    <= '0;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      sel_q   <= '1;
      cur_q   <= '0;
      ft_q    <= 1'b0;
    end else begin
      c_q     <= c_d;
      dig_q   <= dig_d;
      st_q    <= st_d;
      seg_s_q <= seg_s_d;
      dp_s_q  <= dp_s_d;
      en_s_q  <= en_s_d;
      br_q    <= br_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      sel_q   <= sel_d;
      cur_q   <= cur_d;
      ft_q    <= ft_d;
    end
  end

  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign sel_out    = sel_q;
  assign cur_dig    = cur_q;
  assign frame_tick = ft_q;

endmodule
